// File: rtl/i2c_target_capture.sv
// I2C target that captures write bytes into an RX FIFO and serves read bytes from a
// tx_data/tx_valid source, reporting a per-transfer summary at STOP.
module i2c_target_capture #(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    FIFO_DEPTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  xfer_done,
    output logic                  xfer_op,
    output logic [7:0]            xfer_count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int MAX_BITS = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA; all flops reset to the idle-bus level.
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    logic [1:0] pin_prev;

    assign pin_raw = {scl, sda_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
            assign pin_prev[gi] = prev_reg;
        end
    endgenerate

    logic scl_sync, sda_sync, scl_rise, scl_fall, start_evt, stop_evt;
    assign scl_sync  = pin_sync[1];
    assign sda_sync  = pin_sync[0];
    assign scl_rise  = pin_sync[1] & ~pin_prev[1];
    assign scl_fall  = ~pin_sync[1] & pin_prev[1];
    // SCL must be stable high across the SDA edge, so a coincident SCL edge is not a bus condition.
    assign start_evt = pin_sync[1] & pin_prev[1] & pin_prev[0] & ~pin_sync[0];
    assign stop_evt  = pin_sync[1] & pin_prev[1] & ~pin_prev[0] & pin_sync[0];

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [ADDR_WIDTH:0]     addr_sh_reg, addr_sh_next;
    logic [DATA_WIDTH-1:0]   data_sh_reg, data_sh_next;
    logic                    rw_reg, rw_next;
    logic                    matched_reg, matched_next;
    logic                    sda_oe_reg, sda_oe_next;
    logic                    busy_reg, busy_next;
    logic                    xfer_done_reg, xfer_done_next;
    logic                    xfer_op_reg, xfer_op_next;
    logic [7:0]              xfer_count_reg, xfer_count_next;
    logic                    overflow_reg, overflow_next;
    logic                    underflow_reg, underflow_next;
    logic                    tx_ready_reg, tx_ready_next;
    logic [AW:0]             wr_ptr_reg, rd_ptr_reg;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

    logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                    rd_load, count_inc;
    logic [DATA_WIDTH-1:0]   load_val;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_pop   = rx_ready & ~fifo_empty;
    assign load_val   = tx_valid ? tx_data : '1;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        addr_sh_next    = addr_sh_reg;
        data_sh_next    = data_sh_reg;
        rw_next         = rw_reg;
        matched_next    = matched_reg;
        sda_oe_next     = sda_oe_reg;
        busy_next       = busy_reg;
        xfer_done_next  = 1'b0;
        xfer_op_next    = xfer_op_reg;
        xfer_count_next = xfer_count_reg;
        overflow_next   = overflow_reg;
        underflow_next  = underflow_reg;
        tx_ready_next   = 1'b0;
        fifo_push       = 1'b0;
        rd_load         = 1'b0;
        count_inc       = 1'b0;

        if (start_evt) begin
            state_next   = S_ADDR;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b1;
            matched_next = 1'b0;
        end else if (stop_evt) begin
            state_next     = S_IDLE;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
            matched_next   = 1'b0;
            xfer_done_next = matched_reg;
        end else if (scl_rise) begin
            case (state_reg)
                S_ADDR: begin
                    if (bit_cnt_reg < ADDR_BITS) begin
                        addr_sh_next = {addr_sh_reg[ADDR_WIDTH-1:0], sda_sync};
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
                S_WR_DATA: begin
                    if (bit_cnt_reg < DATA_BITS) begin
                        data_sh_next = {data_sh_reg[DATA_WIDTH-2:0], sda_sync};
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
                S_RD_DATA: begin
                    if (bit_cnt_reg < DATA_BITS) begin
                        data_sh_next = {data_sh_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
                S_RD_ACK: begin
                    if (!sda_sync) begin
                        count_inc = 1'b1;
                    end else begin
                        state_next = S_IGNORE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_reg)
                S_ADDR: begin
                    if (bit_cnt_reg == ADDR_BITS) begin
                        if (addr_sh_reg[ADDR_WIDTH:1] == TARGET_ADDR) begin
                            state_next      = S_ADDR_ACK;
                            sda_oe_next     = 1'b1;
                            rw_next         = addr_sh_reg[0];
                            matched_next    = 1'b1;
                            xfer_op_next    = addr_sh_reg[0];
                            xfer_count_next = 8'd0;
                        end else begin
                            state_next = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    bit_cnt_next = '0;
                    if (rw_reg) begin
                        rd_load    = 1'b1;
                        state_next = S_RD_DATA;
                    end else begin
                        sda_oe_next = 1'b0;
                        state_next  = S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (bit_cnt_reg == DATA_BITS) begin
                        state_next = S_WR_ACK;
                        // A pop in the same cycle frees the slot this push needs.
                        if (!fifo_full || fifo_pop) begin
                            fifo_push   = 1'b1;
                            sda_oe_next = 1'b1;
                            count_inc   = 1'b1;
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                end
                S_WR_ACK: begin
                    sda_oe_next  = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = S_WR_DATA;
                end
                S_RD_DATA: begin
                    if (bit_cnt_reg == DATA_BITS) begin
                        sda_oe_next = 1'b0;
                        state_next  = S_RD_ACK;
                    end else begin
                        sda_oe_next = ~data_sh_reg[DATA_WIDTH-1];
                    end
                end
                S_RD_ACK: begin
                    // Only reached after an ACK; a NACK already moved to IGNORE.
                    rd_load      = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = S_RD_DATA;
                end
                default: ;
            endcase
        end

        if (rd_load) begin
            data_sh_next = load_val;
            sda_oe_next  = ~load_val[DATA_WIDTH-1];
            if (tx_valid) begin
                tx_ready_next = 1'b1;
            end else begin
                underflow_next = 1'b1;
            end
        end

        if (count_inc && xfer_count_reg != 8'hFF) begin
            xfer_count_next = xfer_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            bit_cnt_reg    <= '0;
            addr_sh_reg    <= '0;
            data_sh_reg    <= '0;
            rw_reg         <= 1'b0;
            matched_reg    <= 1'b0;
            sda_oe_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            xfer_done_reg  <= 1'b0;
            xfer_op_reg    <= 1'b0;
            xfer_count_reg <= 8'd0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            tx_ready_reg   <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            addr_sh_reg    <= addr_sh_next;
            data_sh_reg    <= data_sh_next;
            rw_reg         <= rw_next;
            matched_reg    <= matched_next;
            sda_oe_reg     <= sda_oe_next;
            busy_reg       <= busy_next;
            xfer_done_reg  <= xfer_done_next;
            xfer_op_reg    <= xfer_op_next;
            xfer_count_reg <= xfer_count_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
            tx_ready_reg   <= tx_ready_next;
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= data_sh_reg;
        end
    end

    assign sda_oe     = sda_oe_reg;
    assign rx_data    = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign rx_valid   = ~fifo_empty;
    assign tx_ready   = tx_ready_reg;
    assign xfer_done  = xfer_done_reg;
    assign xfer_op    = xfer_op_reg;
    assign xfer_count = xfer_count_reg;
    assign busy       = busy_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: doc/i2c_target_capture.md
I2C_TARGET_CAPTURE -- requirements
Module: i2c_target_capture

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: target address width; only 7 is legal.
REQ-002 Parameter DATA_WIDTH, default 8: bits per transferred byte before each ACK slot.
REQ-003 Parameter FIFO_DEPTH, default 16: RX FIFO entries, power of two, 2..256.
REQ-004 Parameter TARGET_ADDR, default 7'h22: address this block answers to.
REQ-005 Port clk, input, 1: system clock; must be at least 8x the SCL rate.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port scl, input, 1: bus clock, asynchronous.
REQ-008 Port sda_i, input, 1: bus data, asynchronous.
REQ-009 Port sda_oe, output, 1: 1 = pull SDA low; 0 = release SDA (open-drain).
REQ-010 Port rx_data, output, DATA_WIDTH: RX FIFO head.
REQ-011 Port rx_valid, output, 1: RX FIFO non-empty.
REQ-012 Port rx_ready, input, 1: pop RX head when rx_valid=1.
REQ-013 Port tx_data, input, DATA_WIDTH: next read byte.
REQ-014 Port tx_valid, input, 1: tx_data available.
REQ-015 Port tx_ready, output, 1: one-cycle pulse; tx_data consumed.
REQ-016 Port xfer_done, output, 1: one-cycle pulse at STOP ending an addressed transfer.
REQ-017 Port xfer_op, output, 1: 0 = write, 1 = read; valid with xfer_done.
REQ-018 Port xfer_count, output, 8: data bytes ACKed in the transfer, saturating at 255; valid with xfer_done.
REQ-019 Port busy, output, 1: high from START to STOP.
REQ-020 Port overflow, output, 1: sticky; cleared only by rst.
REQ-021 Port underflow, output, 1: sticky; cleared only by rst.

Function
REQ-022 Synchronise scl and sda_i through 2 flops each, then detect edges on the synchronised values; bus events therefore lag the pins by 3 clk cycles.
REQ-023 START: synchronised SDA falls while synchronised SCL is high. STOP: SDA rises while SCL is high.
REQ-024 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-025 START from any state, including a repeated START: enter ADDR, clear the bit counter, release sda_oe, set busy.
REQ-026 STOP from any state: enter IDLE, release sda_oe, clear busy.
REQ-027 STOP after a matched address: pulse xfer_done with xfer_op and xfer_count in the same cycle. A repeated START does not pulse xfer_done.
REQ-028 Sample bits on SCL rising edges, MSB first.
REQ-029 Change sda_oe only on SCL falling edges.
REQ-030 ADDR collects 7 address bits plus the R/W bit.
REQ-031 Address match: go to ADDR_ACK and drive sda_oe=1 for exactly one SCL period.
REQ-032 Address mismatch: go to IGNORE; sda_oe stays 0 until the next START or STOP.
REQ-033 Write path: after DATA_WIDTH bits in WR_DATA, go to WR_ACK.
REQ-034 Write, FIFO not full: push the byte, ACK it (sda_oe=1), increment xfer_count.
REQ-035 Write, FIFO full: drop the byte, NACK (sda_oe=0), set overflow; the state machine continues in WR_DATA.
REQ-036 Read path: on the SCL falling edge that ends ADDR_ACK or an ACKed RD_ACK, load the shifter from tx_data and pulse tx_ready, if tx_valid=1.
REQ-037 Read, tx_valid=0 at load time: load all-ones and set underflow.
REQ-038 Read, driving bits: sda_oe = NOT current bit.
REQ-039 Read, after DATA_WIDTH bits: release SDA, then sample the controller ACK in RD_ACK.
REQ-040 Read ACK (SDA=0): increment xfer_count and continue in RD_DATA. NACK: go to IGNORE.
REQ-041 RX FIFO simultaneous push and pop when full: both succeed, with no overflow.
REQ-042 RX FIFO pop when empty: ignored.
REQ-043 rx_data is valid combinationally whenever rx_valid=1.

Reset
REQ-044 rst while busy aborts the transfer with no xfer_done pulse.
REQ-045 On rst, all outputs are 0: sda_oe, rx_valid, tx_ready, xfer_done, xfer_op, xfer_count, busy, overflow, underflow.
REQ-046 On rst, the state is IDLE, both FIFO pointers are 0, and both synchroniser flops are 1 (idle bus).

Verification
REQ-047 Write 0x44 (addr 0x22, W), data 0xA5, 0x3C, STOP -> both ACKed; rx pops A5 then 3C; xfer_done with xfer_op=0, xfer_count=2.
REQ-048 Address 0x23 followed by 3 bytes -> sda_oe never asserted; no FIFO push; no xfer_done.
REQ-049 Read 0x45, tx_valid=1 with 0x96, controller NACKs -> SDA shows 0x96; one tx_ready pulse; xfer_done with xfer_op=1, xfer_count=0.
REQ-050 FIFO_DEPTH=4, write 6 bytes with rx_ready=0 -> bytes 1-4 ACKed, bytes 5-6 NACKed; overflow=1; 4 bytes stored.
REQ-051 Write 1 byte, repeated START, read 0x45 with tx_valid=0, controller NACK -> underflow=1; SDA reads 0xFF; single xfer_done with xfer_op=1.
REQ-052 rst asserted mid-byte -> all outputs 0 next cycle; a following full write transfer completes normally.
